// File: rtl/adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package adder_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: sum = a^b^cin, carry = majority(a, b, cin).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ cin;
  assign carry = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, one bit per clock, LSB first.
// Start/busy/done handshake; sum/cout only update on the completion edge.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry_q;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;

  // The only arithmetic: current LSBs of the operand shifters plus the stored carry.
  full_adder u_fa (sh_a[0], sh_b[0], carry_q, fa_sum, fa_carry);

  // Cell sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  assign res_next = (res >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // FSM, datapath shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            sh_a    <= a;
            sh_b    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          res     <= res_next;
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry_q <= fa_carry;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_next;
            cout  <= fa_carry;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus handshake corner cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[9];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Apply one table entry and check latency, busy width, result and done pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int bcnt;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~v.a; b = ~v.b; cin = ~v.cin;   // must not disturb the add in flight
    cyc = 0; bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d done", idx), int'(done), 1);
    chk($sformatf("v%0d latency", idx), cyc, W);
    chk($sformatf("v%0d busy_cycles", idx), bcnt, W);
    chk($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
    chk($sformatf("v%0d sum", idx), int'(sum), int'(v.s));
    chk($sformatf("v%0d cout", idx), int'(cout), int'(v.co));
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), int'(done), 0);
  endtask

  initial begin
    int cyc;
    int dcnt;
    int hold_bad;
    logic [W-1:0] seen;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[8] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst sum", int'(sum), 0);
    chk("rst cout", int'(cout), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Start while busy: second request three cycles in is dropped.
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin dcnt++; seen = sum; end
      @(negedge clk);
    end
    chk("busy_start done_count", dcnt, 1);
    chk("busy_start sum", int'(seen), 8'h30);

    // Reset mid-operation: outputs clear at once, no done afterwards.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst sum", int'(sum), 0);
    chk("midrst cout", int'(cout), 0);
    chk("midrst busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("midrst no_done", dcnt, 0);
    chk("midrst sum_after", int'(sum), 0);

    // Back-to-back: start accepted in the done cycle; sum holds in between.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("b2b first_done", int'(done), 1);
    chk("b2b first_sum", int'(sum), 8'h10);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hold_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (sum !== 8'h10) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    chk("b2b latency", cyc, W);
    chk("b2b hold", hold_bad, 0);
    chk("b2b sum", int'(sum), 8'h00);
    chk("b2b cout", int'(cout), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
